ecc_pipe_sched: RTL
===================

Name: ecc_pipe_sched

Overview:
- Shares one 3-stage encode -> error-inject -> decode datapath among NREQ requesters.
- Round-robin arbitration admits at most one job per cycle into the pipeline.
- A valid/tag/reference shift chain runs alongside the datapath and steers each result back to its requester.
- Sits between the test/traffic sources and the existing encoder, large_xor and decoder instances; owns all pipeline registers, stall control and result statistics.

Parameters:
- NREQ, 4, number of requesters (2..8).
- DATA_W, 4, message width, matching encoder input and decoder output.
- CODE_W, 15, codeword width, matching encoder output and large_xor operands.
- CNT_W, 16, width of the saturating statistics counters.

Ports:
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- req_valid  in  NREQ  per-requester job request.
- req_data  in  NREQ*DATA_W  per-requester message; slice i belongs to requester i.
- req_err  in  NREQ*CODE_W  per-requester channel error pattern, XORed onto the codeword.
- req_ready  out  NREQ  one-hot grant; a job is accepted when req_valid[i] and req_ready[i] are both high at a clk edge.
- resp_valid  out  1  result available.
- resp_ready  in  1  consumer accepts the result.
- resp_id  out  $clog2(NREQ)  requester index of the result.
- resp_data  out  DATA_W  decoded message.
- resp_mismatch  out  1  resp_data differs from the original req_data of that job.
- jobs_cnt  out  CNT_W  jobs completed (saturating).
- mismatch_cnt  out  CNT_W  completed jobs with resp_mismatch=1 (saturating).

Behaviour:
- Pipeline
  - S1 registers the message, error pattern, id and valid.
  - encoder output is combinational from S1.
  - S2 registers the codeword, error pattern, id, original data and valid.
  - large_xor output is combinational from S2.
  - S3 registers the corrupted word, id, original data and valid.
  - decoder is combinational from S3 and drives resp_data.
  - resp_mismatch = (resp_data != S3 original data).
  - resp_valid = S3 valid.
- Latency: a job accepted at edge k gives resp_valid=1 in the cycle after edge k+2, i.e. 3 edges.
- Throughput: 1 job per cycle when not stalled.
- stall = resp_valid & ~resp_ready.
  - During stall all stage registers hold, req_ready=0, and the RR pointer holds.
  - Stall does not compress bubbles.
- Arbitration
  - Mask-based round-robin. Priority starts at ptr and wraps modulo NREQ.
  - The grant goes to the first requester with req_valid set.
  - req_ready is one-hot or all-zero, and never asserted during stall.
  - On a grant to requester g, ptr <= (g+1) mod NREQ. With no grant, ptr holds.
  - req_ready depends combinationally on req_valid. A requester must hold req_valid and its data stable until accepted.
- Stage valid with no grant: if not stalled and there is no grant, S1 valid loads 0 (bubble).
- Counters
  - jobs_cnt increments on a resp_valid & resp_ready edge.
  - mismatch_cnt increments on the same edge when resp_mismatch=1 as well.
  - Both saturate at all-ones and never wrap.
- Reset
  - All stage valids = 0, ptr = 0, counters = 0.
  - Therefore resp_valid = 0 and req_ready = 0 during the reset cycle. Stage data registers are also cleared to 0.
  - Reset asserted mid-operation drops all in-flight jobs with no response. The first grant after reset deassertion goes to the lowest index starting at 0.
- Simultaneous events: a resp handshake and a new grant on the same edge are both legal; the pipeline advances one slot.
- Boundary: a single requester continuously valid receives a grant every unstalled cycle. With all requesters valid, grants run 0,1,2,3,0,...

Decomposition:
- Package ecc_pipe_pkg holds:
  - DATA_W, CODE_W and ID_W = $clog2(NREQ).
  - Typedef stage_t: valid, id, data, err, code.
- Sub-module rr_arbiter (NREQ): inputs req, en and ptr update; outputs one-hot gnt and gnt index.
- encoder, large_xor and decoder are instantiated unchanged.

Test Plan:
- Reset, then requester 0 sends data=4'hA, err=0 -> in the 3rd cycle after acceptance resp_valid=1, resp_id=0, resp_data=4'hA, resp_mismatch=0, jobs_cnt=1.
- Requester 2 sends data=4'h5, err=15'h0200 (single bit) -> resp_data=4'h5, resp_mismatch=0. Requester 1 with err=15'h0280 (two bits) -> resp_mismatch=1, mismatch_cnt=1.
- All 4 requesters held valid for 8 cycles -> grant order 0,1,2,3,0,1,2,3. The resp_id sequence is identical, 3 cycles delayed, with no gaps.
- Hold resp_ready=0 for 5 cycles with 3 jobs in flight -> resp_valid stays high on the same id and data, req_ready=0 throughout. After release, the 3 results drain in order on consecutive cycles.
- Assert reset for 1 cycle with 3 jobs in flight -> no further resp_valid, counters read 0. The next grant goes to requester 0 when it is valid.
- Preload jobs_cnt to near saturation by force, or use CNT_W=4 with 20 jobs -> jobs_cnt stops at 4'hF.

Source files
------------

// File: rtl/ecc_pipe_pkg.sv
// ecc_pipe_pkg: shared widths, the pipeline stage record and the Hamming
// syndrome helper used by both the encoder and the decoder.
// No ports.
// Code layout: Hamming(15,11) with only four message bits populated.
//   Bit i of the codeword carries Hamming position i+1. Parity sits at
//   positions 1,2,4,8 (bits 0,1,3,7). The message sits at positions 9..12
//   (bits 8..11). All other positions are zero.
package ecc_pipe_pkg;

    localparam int NREQ     = 4;
    localparam int DATA_W   = 4;
    localparam int CODE_W   = 15;
    localparam int ID_W     = $clog2(NREQ);
    localparam int SYN_W    = 4;
    localparam int DATA_LSB = 8;

    typedef struct packed {
        logic              valid;
        logic [ID_W-1:0]   id;
        logic [DATA_W-1:0] data;
        logic [CODE_W-1:0] err;
        logic [CODE_W-1:0] code;
    } stage_t;

    // XOR of the positions of all set bits. Zero for a valid codeword;
    // for a single flipped bit it equals that bit's position.
    function automatic logic [SYN_W-1:0] ham_syndrome(input logic [CODE_W-1:0] word);
        logic [SYN_W-1:0] syn;
        syn = {SYN_W{1'b0}};
        for (int i = 0; i < CODE_W; i++) begin
            syn = syn ^ (word[i] ? SYN_W'(i + 1) : {SYN_W{1'b0}});
        end
        return syn;
    endfunction

endpackage

// File: rtl/decoder.sv
// decoder: single-error-correcting Hamming decode of the message bits.
// Two-bit errors miscorrect and may leave a message bit flipped.
// Ports: code (possibly corrupted codeword in), data (message out).
module decoder
    import ecc_pipe_pkg::*;
(
    input  logic [CODE_W-1:0] code,
    output logic [DATA_W-1:0] data
);

    logic [SYN_W-1:0] syn_s;

    // Flip a message bit only when the syndrome points at its position.
    always_comb begin
        syn_s = ham_syndrome(code);
        data  = {DATA_W{1'b0}};
        for (int j = 0; j < DATA_W; j++) begin
            data[j] = code[DATA_LSB + j] ^ (syn_s == SYN_W'(DATA_LSB + 1 + j));
        end
    end

endmodule

// File: rtl/encoder.sv
// encoder: places the message at bits 8..11 and fills the four parity
// bits so that the codeword syndrome is zero.
// Ports: data (message in), code (codeword out).
module encoder
    import ecc_pipe_pkg::*;
(
    input  logic [DATA_W-1:0] data,
    output logic [CODE_W-1:0] code
);

    logic [CODE_W-1:0] data_word_s;
    logic [SYN_W-1:0]  par_s;

    // The parity bits are exactly the syndrome of the message-only word.
    always_comb begin
        data_word_s                      = {CODE_W{1'b0}};
        data_word_s[DATA_LSB +: DATA_W]  = data;
        par_s                            = ham_syndrome(data_word_s);
        code                             = data_word_s;
        code[0]                          = par_s[0];
        code[1]                          = par_s[1];
        code[3]                          = par_s[2];
        code[7]                          = par_s[3];
    end

endmodule

// File: rtl/large_xor.sv
// large_xor: bitwise XOR of two codeword-wide operands (channel error).
// Ports: a, b (operands), y (a ^ b).
module large_xor
    import ecc_pipe_pkg::*;
(
    input  logic [CODE_W-1:0] a,
    input  logic [CODE_W-1:0] b,
    output logic [CODE_W-1:0] y
);

    assign y = a ^ b;

endmodule

// File: rtl/rr_arbiter.sv
// rr_arbiter: mask-based round-robin arbiter with internal priority pointer.
// Ports: clk, reset (sync, active-high), req (requests), en (grant enable),
//        gnt (one-hot grant), gnt_idx (grant index), gnt_any (a grant exists).
// The pointer advances to one past the winner only when a grant is issued.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NREQ-1:0] req,
    input  logic            en,
    output logic [NREQ-1:0] gnt,
    output logic [IW-1:0]   gnt_idx,
    output logic            gnt_any
);

    logic [IW-1:0] ptr_r;
    logic [IW-1:0] cand_s;
    logic          found_s;

    // Scan from ptr upward with wrap; first active request wins.
    always_comb begin
        gnt     = {NREQ{1'b0}};
        gnt_idx = {IW{1'b0}};
        found_s = 1'b0;
        cand_s  = {IW{1'b0}};
        for (int off = 0; off < NREQ; off++) begin
            cand_s = (int'(ptr_r) + off >= NREQ) ? IW'(int'(ptr_r) + off - NREQ)
                                                 : IW'(int'(ptr_r) + off);
            if (en && !found_s && req[cand_s]) begin
                found_s      = 1'b1;
                gnt[cand_s]  = 1'b1;
                gnt_idx      = cand_s;
            end else begin
                found_s      = found_s;
            end
        end
    end

    assign gnt_any = found_s;

    // Priority pointer: restart at 0 on reset, move past each winner.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_r <= {IW{1'b0}};
        end else if (found_s) begin
            ptr_r <= (gnt_idx == IW'(NREQ - 1)) ? {IW{1'b0}} : gnt_idx + IW'(1);
        end else begin
            ptr_r <= ptr_r;
        end
    end

endmodule

// File: rtl/ecc_pipe_sched.sv
// ecc_pipe_sched: shares one encode -> error-inject -> decode pipeline
// among NREQ requesters and returns each result tagged with its requester.
// Ports:
//   clk, reset (sync, active-high)
//   req_valid/req_data/req_err  per-requester job inputs (slice i = requester i)
//   req_ready                   one-hot grant, combinational from req_valid
//   resp_valid/resp_ready       result handshake; resp_valid & ~resp_ready stalls
//   resp_id/resp_data/resp_mismatch  result tag, decoded message, compare flag
//   jobs_cnt/mismatch_cnt       saturating completion statistics
// DATA_W/CODE_W/NREQ must match the ecc_pipe_pkg values.
module ecc_pipe_sched
    import ecc_pipe_pkg::stage_t;
#(
    parameter int NREQ   = ecc_pipe_pkg::NREQ,
    parameter int DATA_W = ecc_pipe_pkg::DATA_W,
    parameter int CODE_W = ecc_pipe_pkg::CODE_W,
    parameter int CNT_W  = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ*DATA_W-1:0]   req_data,
    input  logic [NREQ*CODE_W-1:0]   req_err,
    output logic [NREQ-1:0]          req_ready,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [$clog2(NREQ)-1:0]  resp_id,
    output logic [DATA_W-1:0]        resp_data,
    output logic                     resp_mismatch,
    output logic [CNT_W-1:0]         jobs_cnt,
    output logic [CNT_W-1:0]         mismatch_cnt
);

    localparam int IW = $clog2(NREQ);

    stage_t            s1_r, s2_r, s1_n_s, s2_n_s;
    logic              s3_valid_r;
    logic [IW-1:0]     s3_id_r;
    logic [DATA_W-1:0] s3_data_r;
    logic [CODE_W-1:0] s3_word_r;

    logic              stall_s, arb_en_s, gnt_any_s, fire_s;
    logic [NREQ-1:0]   gnt_s;
    logic [IW-1:0]     gnt_idx_s;
    logic [DATA_W-1:0] job_data_s;
    logic [CODE_W-1:0] job_err_s;
    logic [CODE_W-1:0] enc_code_s, xor_word_s;
    logic [CNT_W-1:0]  jobs_cnt_r, mismatch_cnt_r;

    assign stall_s  = s3_valid_r & ~resp_ready;
    assign fire_s   = s3_valid_r & resp_ready;
    assign arb_en_s = ~stall_s & ~reset;

    rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_arb (
        .clk     (clk),
        .reset   (reset),
        .req     (req_valid),
        .en      (arb_en_s),
        .gnt     (gnt_s),
        .gnt_idx (gnt_idx_s),
        .gnt_any (gnt_any_s)
    );

    assign req_ready = gnt_s;

    // Pick the granted requester's message and error pattern.
    always_comb begin
        job_data_s = {DATA_W{1'b0}};
        job_err_s  = {CODE_W{1'b0}};
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_s[i]) begin
                job_data_s = req_data[i*DATA_W +: DATA_W];
                job_err_s  = req_err[i*CODE_W +: CODE_W];
            end else begin
                job_data_s = job_data_s;
            end
        end
    end

    // Stage inputs: S1 takes the new job (or a bubble), S2 adds the codeword.
    always_comb begin
        s1_n_s       = '0;
        s1_n_s.valid = gnt_any_s;
        s1_n_s.id    = gnt_idx_s;
        s1_n_s.data  = job_data_s;
        s1_n_s.err   = job_err_s;
        s2_n_s       = s1_r;
        s2_n_s.code  = enc_code_s;
    end

    encoder   u_enc (.data(s1_r.data), .code(enc_code_s));
    large_xor u_xor (.a(s2_r.code), .b(s2_r.err), .y(xor_word_s));
    decoder   u_dec (.code(s3_word_r), .data(resp_data));

    // Pipeline registers: all stages hold together while stalled.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_r       <= '0;
            s2_r       <= '0;
            s3_valid_r <= 1'b0;
            s3_id_r    <= {IW{1'b0}};
            s3_data_r  <= {DATA_W{1'b0}};
            s3_word_r  <= {CODE_W{1'b0}};
        end else if (!stall_s) begin
            s1_r       <= s1_n_s;
            s2_r       <= s2_n_s;
            s3_valid_r <= s2_r.valid;
            s3_id_r    <= s2_r.id;
            s3_data_r  <= s2_r.data;
            s3_word_r  <= xor_word_s;
        end else begin
            s1_r       <= s1_r;
            s2_r       <= s2_r;
            s3_valid_r <= s3_valid_r;
            s3_id_r    <= s3_id_r;
            s3_data_r  <= s3_data_r;
            s3_word_r  <= s3_word_r;
        end
    end

    assign resp_valid    = s3_valid_r;
    assign resp_id       = s3_id_r;
    assign resp_mismatch = (resp_data != s3_data_r);

    // Saturating completion statistics, counted on each result handshake.
    always_ff @(posedge clk) begin
        if (reset) begin
            jobs_cnt_r     <= {CNT_W{1'b0}};
            mismatch_cnt_r <= {CNT_W{1'b0}};
        end else begin
            if (fire_s && !(&jobs_cnt_r)) begin
                jobs_cnt_r <= jobs_cnt_r + CNT_W'(1);
            end else begin
                jobs_cnt_r <= jobs_cnt_r;
            end
            if (fire_s && resp_mismatch && !(&mismatch_cnt_r)) begin
                mismatch_cnt_r <= mismatch_cnt_r + CNT_W'(1);
            end else begin
                mismatch_cnt_r <= mismatch_cnt_r;
            end
        end
    end

    assign jobs_cnt     = jobs_cnt_r;
    assign mismatch_cnt = mismatch_cnt_r;

endmodule
